// File: rtl/steelhorse_recv_drain_if.sv
// Bus interface between the Steelhorse receive buffer port and the drain stream.
//   Steelhorse side: DATA_ADDR, DATA_RECV, WRITE_DATA_RECV, NWPCKT_IRQ_VALID, RECV_LEN
//   Stream side    : OUT_DATA, OUT_VALID, OUT_LAST (to consumer), OUT_READY (from consumer)
// master = Steelhorse/consumer environment, slave = steelhorse_recv_drain.
interface steelhorse_recv_drain_if #(
  parameter int unsigned LEN_W = 16
);
  logic [9:0]       DATA_ADDR;
  logic [31:0]      DATA_RECV;
  logic             WRITE_DATA_RECV;
  logic             NWPCKT_IRQ_VALID;
  logic [LEN_W-1:0] RECV_LEN;
  logic [31:0]      OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_LAST;

  modport master (
    output DATA_ADDR, DATA_RECV, WRITE_DATA_RECV, NWPCKT_IRQ_VALID, RECV_LEN, OUT_READY,
    input  OUT_DATA, OUT_VALID, OUT_LAST
  );

  modport slave (
    input  DATA_ADDR, DATA_RECV, WRITE_DATA_RECV, NWPCKT_IRQ_VALID, RECV_LEN, OUT_READY,
    output OUT_DATA, OUT_VALID, OUT_LAST
  );
endinterface

// File: rtl/steelhorse_recv_drain.sv
// Receive-side drain for the Steelhorse buffer port (recv_CLK domain).
// Captures received words into a two-bank buffer; on a good-frame pulse the
// filled bank is handed to a reader that streams it out over valid/ready.
// Ports:
//   CLK        recv_CLK clock
//   RST        asynchronous active-low reset
//   bus        steelhorse_recv_drain_if.slave (write port in, stream out)
//   PCKT_LEN   byte length of the frame being streamed (clipped to bank size)
//   BUSY       reader bank owned by the stream
//   DROP_COUNT frames dropped while the reader was busy, saturating
module steelhorse_recv_drain #(
  parameter int unsigned WORDS = 128,
  parameter int unsigned LEN_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  steelhorse_recv_drain_if.slave bus,
  output logic [LEN_W-1:0]   PCKT_LEN,
  output logic               BUSY,
  output logic [7:0]         DROP_COUNT
);

  localparam int unsigned AW      = $clog2(WORDS);
  localparam int unsigned MAX_LEN = WORDS * 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t state, state_d;

  logic [31:0]      mem [2*WORDS];
  logic             wbank;
  logic             rbank;
  logic [AW-1:0]    idx;
  logic [AW-1:0]    last_idx;

  logic             irq_c;
  logic             wr_c;
  logic             accept_c;
  logic             drop_c;
  logic             load_c;
  logic             adv_c;
  logic             fin_c;
  logic [AW-1:0]    idx_nxt_c;
  logic [LEN_W-1:0] len_clip_c;

  // Address bits above the bank index alias onto the same bank word.
  logic unused_addr_c;
  assign unused_addr_c = ^bus.DATA_ADDR[8:AW];

  assign irq_c      = bus.NWPCKT_IRQ_VALID && (bus.RECV_LEN != '0);
  assign wr_c       = bus.WRITE_DATA_RECV && !bus.DATA_ADDR[9];
  assign idx_nxt_c  = idx + AW'(1);
  assign len_clip_c = (bus.RECV_LEN > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.RECV_LEN;

  // Reader state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_d;
  end

  // Reader next-state and datapath strobes.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    drop_c   = 1'b0;
    load_c   = 1'b0;
    adv_c    = 1'b0;
    fin_c    = 1'b0;
    case (state)
      IDLE: begin
        if (irq_c) begin
          accept_c = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        drop_c  = irq_c;
        load_c  = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        drop_c = irq_c;
        // OUT_VALID is always high in STREAM, so OUT_READY alone is the handshake.
        if (bus.OUT_READY) begin
          if (idx == last_idx) begin
            fin_c   = 1'b1;
            state_d = IDLE;
          end else begin
            adv_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer write port; a write coinciding with handoff lands in the outgoing bank.
  always_ff @(posedge CLK) begin
    if (wr_c) mem[{wbank, bus.DATA_ADDR[AW-1:0]}] <= bus.DATA_RECV;
  end

  // Bank ownership, frame bookkeeping and the registered stream outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      idx           <= '0;
      last_idx      <= '0;
      PCKT_LEN      <= '0;
      BUSY          <= 1'b0;
      DROP_COUNT    <= '0;
      bus.OUT_DATA  <= '0;
      bus.OUT_VALID <= 1'b0;
      bus.OUT_LAST  <= 1'b0;
    end else begin
      if (accept_c) begin
        rbank    <= wbank;
        wbank    <= ~wbank;
        PCKT_LEN <= len_clip_c;
        // Index of the final word: ceil(len/4)-1 == (len-1)/4 for len >= 1.
        last_idx <= AW'((len_clip_c - LEN_W'(1)) >> 2);
        BUSY     <= 1'b1;
      end
      if (drop_c && (DROP_COUNT != 8'hff)) DROP_COUNT <= DROP_COUNT + 8'd1;
      if (load_c) begin
        idx           <= '0;
        bus.OUT_DATA  <= mem[{rbank, AW'(0)}];
        bus.OUT_VALID <= 1'b1;
        bus.OUT_LAST  <= (last_idx == '0);
      end
      // Fetch the next word on the accepting edge so beats run back to back.
      if (adv_c) begin
        idx          <= idx_nxt_c;
        bus.OUT_DATA <= mem[{rbank, idx_nxt_c}];
        bus.OUT_LAST <= (idx_nxt_c == last_idx);
      end
      if (fin_c) begin
        bus.OUT_VALID <= 1'b0;
        bus.OUT_LAST  <= 1'b0;
        BUSY          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_steelhorse_recv_drain.sv
// Self-checking bench for steelhorse_recv_drain: directed scenarios plus a
// randomized phase, all outputs compared every cycle against a queue-based model.
module tb_steelhorse_recv_drain;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LEN_W-1:0] pckt_len;
  logic             busy;
  logic [7:0]       drop_count;

  steelhorse_recv_drain_if #(.LEN_W(LEN_W)) bus ();

  steelhorse_recv_drain #(.WORDS(128), .LEN_W(LEN_W)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .bus        (bus.slave),
    .PCKT_LEN   (pckt_len),
    .BUSY       (busy),
    .DROP_COUNT (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: bank memories plus the queue of words still owed to the consumer.
  logic [31:0] m_mem [2][128];
  int          m_wb;
  logic [31:0] m_q [$];
  bit          m_loading;
  int          m_drop;
  int          m_plen;
  bit          mon_en;
  bit          rnd_ready;
  int          hs_cnt;

  task automatic model_reset();
    m_q.delete();
    m_wb      = 0;
    m_loading = 0;
    m_drop    = 0;
    m_plen    = 0;
  endtask

  // At each falling edge: compare outputs, then advance the model across the next rising edge.
  always @(negedge clk) begin
    bit exp_valid;
    bit busy_before;
    int wb_old;
    int plen;
    if (rst_n === 1'b1 && mon_en) begin
      exp_valid = (m_q.size() != 0) && !m_loading;
      check("busy",  32'(busy),          32'(m_q.size() != 0));
      check("valid", 32'(bus.OUT_VALID), 32'(exp_valid));
      if (exp_valid) begin
        check("data", bus.OUT_DATA,       m_q[0]);
        check("last", 32'(bus.OUT_LAST),  32'(m_q.size() == 1));
      end
      check("drop", 32'(drop_count), 32'(m_drop));
      check("plen", 32'(pckt_len),   32'(m_plen));
      if (bus.OUT_VALID && bus.OUT_READY) hs_cnt++;

      busy_before = (m_q.size() != 0);
      wb_old      = m_wb;
      m_loading   = 0;
      if (bus.WRITE_DATA_RECV && !bus.DATA_ADDR[9])
        m_mem[wb_old][int'(bus.DATA_ADDR[6:0])] = bus.DATA_RECV;
      if (exp_valid && bus.OUT_READY) void'(m_q.pop_front());
      if (bus.NWPCKT_IRQ_VALID && bus.RECV_LEN != 0) begin
        if (busy_before) begin
          if (m_drop < 255) m_drop++;
        end else begin
          plen = (int'(bus.RECV_LEN) > 512) ? 512 : int'(bus.RECV_LEN);
          for (int i = 0; i < (plen + 3) / 4; i++) m_q.push_back(m_mem[wb_old][i]);
          m_wb      = 1 - m_wb;
          m_loading = 1;
          m_plen    = plen;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      bus.OUT_READY = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    bus.DATA_ADDR       = 10'(addr);
    bus.DATA_RECV       = data;
    bus.WRITE_DATA_RECV = 1'b1;
    tick();
    bus.WRITE_DATA_RECV = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) wr(i, $urandom);
  endtask

  task automatic pulse(input int len);
    bus.NWPCKT_IRQ_VALID = 1'b1;
    bus.RECV_LEN         = LEN_W'(len);
    tick();
    bus.NWPCKT_IRQ_VALID = 1'b0;
    bus.RECV_LEN         = '0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && m_q.size() != 0; i++) tick();
    check("drain_timeout", 32'(m_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.OUT_VALID), 32'd0);
    check({tag, "_last"},  32'(bus.OUT_LAST),  32'd0);
    check({tag, "_data"},  bus.OUT_DATA,       32'd0);
    check({tag, "_plen"},  32'(pckt_len),      32'd0);
    check({tag, "_busy"},  32'(busy),          32'd0);
    check({tag, "_drop"},  32'(drop_count),    32'd0);
  endtask

  initial begin
    int hs0;
    rst_n                = 1'b0;
    bus.DATA_ADDR        = '0;
    bus.DATA_RECV        = '0;
    bus.WRITE_DATA_RECV  = 1'b0;
    bus.NWPCKT_IRQ_VALID = 1'b0;
    bus.RECV_LEN         = '0;
    bus.OUT_READY        = 1'b0;
    rnd_ready            = 0;
    mon_en               = 0;
    hs_cnt               = 0;
    model_reset();
    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;

    // Known pattern, 16 words, full-rate consumer; two-cycle latency to first beat.
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 16; i++) wr(i, 32'h1234_5678 + 32'(i));
    hs0 = hs_cnt;
    pulse(64);
    check("lat_load_valid", 32'(bus.OUT_VALID), 32'd0);
    check("lat_load_busy",  32'(busy),          32'd1);
    tick();
    check("lat_first_valid", 32'(bus.OUT_VALID), 32'd1);
    check("lat_first_data",  bus.OUT_DATA,       32'h1234_5678);
    drain(40);
    check("t1_beats", 32'(hs_cnt - hs0), 32'd16);
    check("t1_plen",  32'(pckt_len),     32'd64);

    // Odd length and oversize length.
    fill(2);
    pulse(5);
    drain(20);
    check("len5_plen", 32'(pckt_len), 32'd5);
    fill(128);
    hs0 = hs_cnt;
    pulse(1000);
    drain(200);
    check("len1000_plen",  32'(pckt_len),     32'd512);
    check("len1000_beats", 32'(hs_cnt - hs0), 32'd128);

    // Random back-pressure on a 32-word frame.
    fill(32);
    hs0 = hs_cnt;
    rnd_ready = 1;
    pulse(128);
    drain(500);
    rnd_ready = 0;
    tick();
    bus.OUT_READY = 1'b1;
    check("stall_beats", 32'(hs_cnt - hs0), 32'd32);

    // Stalled reader: second frame dropped, its bank overwritten, then streamed later.
    bus.OUT_READY = 1'b0;
    fill(16);
    pulse(64);
    fill(16);
    pulse(64);
    fill(16);
    check("drop_one", 32'(drop_count), 32'd1);
    bus.OUT_READY = 1'b1;
    drain(60);
    tick();
    pulse(64);
    drain(60);

    // Send-side writes and zero-length pulses must not disturb anything.
    for (int i = 0; i < 16; i++) wr(10'h200 | i, $urandom);
    pulse(0);
    repeat (3) tick();
    check("ign_busy", 32'(busy),       32'd0);
    check("ign_drop", 32'(drop_count), 32'd1);
    pulse(64);
    drain(60);

    // Write in the same cycle as the handoff lands in the handed-over bank.
    fill(3);
    bus.DATA_ADDR        = 10'd3;
    bus.DATA_RECV        = 32'hcafe_f00d;
    bus.WRITE_DATA_RECV  = 1'b1;
    pulse(16);
    bus.WRITE_DATA_RECV  = 1'b0;
    drain(20);

    // Randomized traffic: writes anywhere, random pulses and lengths, random ready.
    rnd_ready = 1;
    for (int c = 0; c < 600; c++) begin
      bus.WRITE_DATA_RECV  = 1'($urandom_range(0, 1));
      bus.DATA_ADDR        = 10'($urandom_range(0, 1023));
      bus.DATA_RECV        = $urandom;
      bus.NWPCKT_IRQ_VALID = ($urandom_range(0, 11) == 0);
      bus.RECV_LEN         = LEN_W'($urandom_range(0, 700));
      tick();
    end
    bus.WRITE_DATA_RECV  = 1'b0;
    bus.NWPCKT_IRQ_VALID = 1'b0;
    bus.RECV_LEN         = '0;
    drain(2000);
    rnd_ready = 0;
    tick();
    bus.OUT_READY = 1'b1;

    // Drop counter saturation.
    bus.OUT_READY = 1'b0;
    fill(4);
    pulse(16);
    bus.NWPCKT_IRQ_VALID = 1'b1;
    bus.RECV_LEN         = LEN_W'(4);
    repeat (300) tick();
    bus.NWPCKT_IRQ_VALID = 1'b0;
    bus.RECV_LEN         = '0;
    check("drop_sat", 32'(drop_count), 32'hff);
    bus.OUT_READY = 1'b1;
    drain(20);

    // Asynchronous reset in the middle of a frame, then a fresh frame from bank 0.
    fill(64);
    pulse(256);
    repeat (10) tick();
    check("pre_rst_valid", 32'(bus.OUT_VALID), 32'd1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill(10);
    hs0 = hs_cnt;
    pulse(40);
    tick();
    check("post_rst_valid", 32'(bus.OUT_VALID), 32'd1);
    drain(30);
    check("post_rst_beats", 32'(hs_cnt - hs0), 32'd10);
    check("post_rst_plen",  32'(pckt_len),     32'd40);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
